// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types: FSM state encoding, reset/NOP defaults, hold-buffer payload.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetchState_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } holdEntry_t;

  // Sequential PC step; wraps naturally at 32 bits.
  function automatic logic [XLEN-1:0] nextPc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ready handshake between the fetch stage and imem.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_hold_buf.sv
// Single-entry {instr, pc} buffer that parks a fetched word while decode is stalled.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clear,
  input  holdEntry_t dIn,
  output holdEntry_t q,
  output logic       valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= dIn;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch + IF/ID register with decode-stall hold buffer and execute redirects.
// Optional macro FETCH_MISALIGN_CHECK_EN adds the sticky misalignF output.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              PCSrcE,
  input  logic [XLEN-1:0]   PCTargetE,
  input  logic              stallD,
  input  logic              flushD,
  fetch_stage_if.master     imem,
  output logic [XLEN-1:0]   instrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic              validD
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic              misalignF
`endif
);

  fetchState_t     state, stateNext;
  logic [XLEN-1:0] pcF, pcFNext;
  logic            reqQ, reqNext;
  logic [XLEN-1:0] addrQ, addrNext;
  logic [XLEN-1:0] instrNext, pcDNext, pcPlus4DNext;
  logic            validNext;
  logic            redirect, accept;
  logic [XLEN-1:0] targetAligned;
  logic            bufLoad, bufClear, bufValid;
  holdEntry_t      bufIn, bufQ;

  assign targetAligned = {PCTargetE[XLEN-1:2], 2'b00};
  assign redirect      = PCSrcE && (state != IDLE);
  assign accept        = reqQ && imem.imem_ready;
  assign bufIn         = '{instr: imem.imem_rdata, pc: pcF};

  assign imem.imem_req  = reqQ;
  assign imem.imem_addr = addrQ;

  fetch_hold_buf u_holdBuf (
    .clk   (clk),
    .rst   (rst),
    .load  (bufLoad),
    .clear (bufClear),
    .dIn   (bufIn),
    .q     (bufQ),
    .valid (bufValid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state, fetch PC and buffer control; redirects outrank responses.
  always_comb begin
    stateNext = state;
    pcFNext   = pcF;
    bufLoad   = 1'b0;
    bufClear  = 1'b0;
    case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        if (redirect) begin
          pcFNext   = targetAligned;
          stateNext = accept ? REQ : DROP;
        end else if (accept) begin
          pcFNext = nextPc(pcF);
          if (stallD) begin
            bufLoad   = 1'b1;
            stateNext = HOLD;
          end
        end
      end
      DROP: begin
        if (redirect) pcFNext = targetAligned;
        if (accept)   stateNext = REQ;
      end
      HOLD: begin
        if (redirect) begin
          pcFNext   = targetAligned;
          bufClear  = 1'b1;
          stateNext = REQ;
        end else if (!stallD) begin
          bufClear  = 1'b1;
          stateNext = REQ;
        end
      end
      default: stateNext = IDLE;
    endcase

    // A pending address only advances when a fresh request is issued from REQ.
    reqNext  = (stateNext == REQ) || (stateNext == DROP);
    addrNext = (stateNext == REQ) ? pcFNext : addrQ;
  end

  // IF/ID load selection: squash, then hold, then new word or bubble.
  always_comb begin
    instrNext    = instrD;
    pcDNext      = PCD;
    pcPlus4DNext = PCPlus4D;
    validNext    = validD;
    if (flushD || PCSrcE) begin
      instrNext = NOP_INSTR;
      validNext = 1'b0;
    end else if (!stallD) begin
      if (state == REQ && accept) begin
        instrNext    = imem.imem_rdata;
        pcDNext      = pcF;
        pcPlus4DNext = nextPc(pcF);
        validNext    = 1'b1;
      end else if (state == HOLD) begin
        instrNext    = bufQ.instr;
        pcDNext      = bufQ.pc;
        pcPlus4DNext = nextPc(bufQ.pc);
        validNext    = bufValid;
      end else begin
        instrNext = NOP_INSTR;
        validNext = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcF      <= RESET_PC;
      reqQ     <= 1'b0;
      addrQ    <= RESET_PC;
      instrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      validD   <= 1'b0;
    end else begin
      pcF      <= pcFNext;
      reqQ     <= reqNext;
      addrQ    <= addrNext;
      instrD   <= instrNext;
      PCD      <= pcDNext;
      PCPlus4D <= pcPlus4DNext;
      validD   <= validNext;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       misalignF <= 1'b0;
    else if (redirect && (PCTargetE[1:0] != 2'b00)) misalignF <= 1'b1;
  end
`else
  logic unusedTgtBits;
  assign unusedTgtBits = ^PCTargetE[1:0];
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios, then random traffic vs a program-order model.
`timescale 1ns/1ps
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic [31:0] instrD, PCD, PCPlus4D;
  logic        validD;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalignF;
`endif

  logic        readyDrv = 1'b1;
  logic [31:0] memKey = '0;
  logic [31:0] junk = 32'hDEAD_BEEF;
  int          errors = 0;
  int          checks = 0;

  // Random-phase model state
  int          delivered = 0;
  logic [31:0] expPc;
  logic        pReq, pReady, pStall, pRedir, pValid;
  logic [31:0] pAddr, pTarget, pInstr;

  fetch_stage_if mi();

  // Memory model: word at address a is a ^ memKey, garbage when not ready.
  assign mi.imem_ready = readyDrv;
  assign mi.imem_rdata = readyDrv ? (mi.imem_addr ^ memKey) : junk;

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .stallD    (stallD),
    .flushD    (flushD),
    .imem      (mi),
    .instrD    (instrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .validD    (validD)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalignF (misalignF)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ memKey;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfId(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                           input logic v);
    check({tag, "_instr"}, instrD, ins);
    check({tag, "_pc"}, PCD, pc);
    check({tag, "_valid"}, 32'(validD), 32'(v));
  endtask

  task automatic checkReq(input string tag, input logic r, input logic [31:0] a);
    check({tag, "_req"}, 32'(mi.imem_req), 32'(r));
    if (r) check({tag, "_addr"}, mi.imem_addr, a);
  endtask

  initial begin
    // Reset values
    tick(); tick();
    checkReq("rst", 1'b0, 32'h0);
    check("rst_addr", mi.imem_addr, RESET_PC);
    check("rst_instr", instrD, NOP_INSTR);
    check("rst_pcd", PCD, 32'h0);
    check("rst_pc4", PCPlus4D, 32'h0);
    check("rst_valid", 32'(validD), 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("rst_misalign", 32'(misalignF), 32'h0);
`endif

    // Release, zero-wait memory, word == address
    rst = 1'b0;
    check("first_cycle_req", 32'(mi.imem_req), 32'h0);
    tick();
    checkReq("c2", 1'b1, 32'h0);
    check("c2_valid", 32'(validD), 32'h0);
    for (int k = 2; k <= 3; k++) begin
      tick();
      checkReq("stream", 1'b1, 32'(4 * (k - 1)));
      check("stream_eq", instrD, PCD);
      checkIfId("stream", 32'(4 * (k - 2)), 32'(4 * (k - 2)), 1'b1);
    end

    // Wait states at addr 8
    readyDrv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkReq("wait", 1'b1, 32'h8);
      checkIfId("wait", NOP_INSTR, 32'h4, 1'b0);
    end
    readyDrv = 1'b1;
    memKey   = 32'h5A5A_0000;
    tick();
    checkIfId("wait_done", word(32'h8), 32'h8, 1'b1);
    checkReq("wait_done", 1'b1, 32'hC);

    // Decode stall while the word at 12 returns
    stallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkReq("stall", 1'b0, 32'h0);
      checkIfId("stall", word(32'h8), 32'h8, 1'b1);
    end
    stallD = 1'b0;
    tick();
    checkIfId("unstall", word(32'hC), 32'hC, 1'b1);
    checkReq("unstall", 1'b1, 32'h10);
    tick();
    checkIfId("resume", word(32'h10), 32'h10, 1'b1);

    // Redirect while 0x20 is pending
    tick(); tick(); tick();
    checkReq("pre_redir", 1'b1, 32'h20);
    readyDrv  = 1'b0;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h100;
    tick();
    PCSrcE = 1'b0;
    checkReq("drop1", 1'b1, 32'h20);
    checkIfId("drop1", NOP_INSTR, 32'h1C, 1'b0);
    tick();
    checkReq("drop2", 1'b1, 32'h20);
    check("drop2_valid", 32'(validD), 32'h0);
    readyDrv = 1'b1;
    tick();
    checkReq("after_drop", 1'b1, 32'h100);
    check("after_drop_instr", instrD, NOP_INSTR);
    tick();
    checkIfId("tgt", word(32'h100), 32'h100, 1'b1);

    // Zero-wait redirect penalty
    PCSrcE    = 1'b1;
    PCTargetE = 32'h200;
    tick();
    PCSrcE = 1'b0;
    check("pen_nop", instrD, NOP_INSTR);
    check("pen_valid", 32'(validD), 32'h0);
    checkReq("pen", 1'b1, 32'h200);
    tick();
    checkIfId("pen_tgt", word(32'h200), 32'h200, 1'b1);

    // flushD together with stallD
    flushD = 1'b1;
    stallD = 1'b1;
    tick();
    flushD = 1'b0;
    stallD = 1'b0;
    check("flush_instr", instrD, NOP_INSTR);
    check("flush_valid", 32'(validD), 32'h0);
    tick();
    checkIfId("flush_buf", word(32'h204), 32'h204, 1'b1);

    // PC wrap
    PCSrcE    = 1'b1;
    PCTargetE = 32'hFFFF_FFF8;
    tick();
    PCSrcE = 1'b0;
    checkReq("wrap0", 1'b1, 32'hFFFF_FFF8);
    tick();
    tick();
    checkIfId("wrap", word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b1);
    check("wrap_pc4", PCPlus4D, 32'h0);
    checkReq("wrap", 1'b1, 32'h0);

    // Misaligned target
    PCSrcE    = 1'b1;
    PCTargetE = 32'h102;
    tick();
    checkReq("mis", 1'b1, 32'h100);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_flag", 32'(misalignF), 32'h1);
`endif
    PCTargetE = 32'h300;
    tick();
    PCSrcE = 1'b0;
    checkReq("mis_realign", 1'b1, 32'h300);
    tick();
    checkIfId("mis_tgt", word(32'h300), 32'h300, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_sticky", 32'(misalignF), 32'h1);
`endif

    // Asynchronous reset mid-request
    readyDrv = 1'b0;
    tick();
    checkReq("pend", 1'b1, 32'h304);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", 32'(mi.imem_req), 32'h0);
    check("arst_addr", mi.imem_addr, RESET_PC);
    checkIfId("arst", NOP_INSTR, 32'h0, 1'b0);
    tick();
    rst   = 1'b0;
    expPc = RESET_PC;

    // Random traffic against program-order model
    for (int c = 0; c < 3000; c++) begin
      readyDrv  = ($urandom_range(0, 3) != 0);
      stallD    = ($urandom_range(0, 4) == 0);
      PCSrcE    = (c > 3) && ($urandom_range(0, 15) == 0);
      PCTargetE = 32'($urandom_range(0, 4095));
      junk      = $urandom;
      pReq      = mi.imem_req;
      pAddr     = mi.imem_addr;
      pReady    = readyDrv;
      pStall    = stallD;
      pRedir    = PCSrcE;
      pTarget   = PCTargetE;
      pInstr    = instrD;
      pValid    = validD;
      tick();
      if (pReq && !pReady) begin
        check("hs_req", 32'(mi.imem_req), 32'h1);
        check("hs_addr", mi.imem_addr, pAddr);
      end
      if (mi.imem_req) check("addr_align", 32'(mi.imem_addr[1:0]), 32'h0);
      if (pRedir) begin
        check("redir_nop", 32'(validD), 32'h0);
        expPc = pTarget & ~32'd3;
      end else if (pStall) begin
        check("hold_instr", instrD, pInstr);
        check("hold_valid", 32'(validD), 32'(pValid));
      end else if (validD) begin
        check("order_pc", PCD, expPc);
        expPc = expPc + 32'd4;
        delivered++;
      end
      if (validD) begin
        check("word", instrD, word(PCD));
        check("pc4", PCPlus4D, PCD + 32'd4);
      end
    end
    check("liveness", 32'(delivered > 150), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage RV32I core. It keeps the fetch PC, issues requests to instruction memory through a req/ready handshake, and delivers instrD / PCD into the decode stage. It also absorbs decode stalls with a one-word hold buffer and applies branch/JALR redirects from execute.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, word loaded into the IF/ID register on flush or when no instruction is valid (addi x0,x0,0)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- PCSrcE  in  1  redirect request from execute (taken branch or jump)
- PCTargetE  in  32  redirect target
- stallD  in  1  decode cannot accept; the IF/ID register holds
- flushD  in  1  load NOP_INSTR into IF/ID
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched word
- instrD  out  32  IF/ID instruction
- PCD  out  32  IF/ID PC
- PCPlus4D  out  32  PCD+4
- validD  out  1  instrD is a real fetched instruction

## Operation
- FSM states: IDLE, REQ, DROP, HOLD.
- IDLE: entered only on reset. imem_req=0. Moves to REQ unconditionally on the next clock.
- REQ: imem_req=1, imem_addr=pcF.
  - PCSrcE=1, any ready: pcF<=PCTargetE, IF/ID<=NOP (validD=0), discard rdata. Next state is REQ if imem_ready, else DROP.
  - imem_ready=1, stallD=0: IF/ID<={rdata, pcF, pcF+4, valid=1}, pcF<=pcF+4.
  - imem_ready=1, stallD=1: buffer<={rdata, pcF}, pcF<=pcF+4, go to HOLD.
- DROP: imem_req=1, imem_addr=the old pending address, held stable. On imem_ready the word is discarded and the state goes to REQ, which then fetches pcF. A PCSrcE in DROP updates pcF again.
- HOLD: imem_req=0.
  - stallD falls: IF/ID<=buffer, valid=1, go to REQ.
  - PCSrcE=1: discard the buffer, pcF<=PCTargetE, IF/ID<=NOP, go to REQ.
- IF/ID register priority, highest first: flushD or PCSrcE -> NOP; then stallD -> hold; then load.
- Handshake rule: once imem_req=1 with no imem_ready, imem_req and imem_addr stay unchanged until imem_ready. This applies in REQ and DROP, including when a redirect arrives.
- pcF arithmetic: 32-bit, +4 wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instrD=NOP_INSTR, PCD=0, PCPlus4D=0, validD=0, pcF=RESET_PC, state=IDLE.
- First imem_req=1 is in the second cycle after rst deasserts.
- Zero-wait memory (imem_ready tied 1): one instruction per cycle. The word appears on instrD one clock after imem_ready.
- Redirect penalty: instrD is a NOP the cycle after PCSrcE. With a zero-wait memory the target instruction appears two cycles after PCSrcE.
- Assertion of rst mid-request: all state returns to the reset values immediately. Any in-flight response is ignored, because the memory is reset by the same rst.
- imem_rdata is sampled only when imem_ready=1 and imem_req=1.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - Adds output misalignF (1 bit, reset 0).
  - A redirect with PCTargetE[1:0]!=0 sets misalignF sticky until reset.
  - pcF takes {PCTargetE[31:2],2'b00}.
- Not defined: the port is absent and PCTargetE[1:0] is silently forced to 0.

## Structure
- Shared core package holds:
  - The state encoding enum: IDLE=2'd0, REQ=2'd1, DROP=2'd2, HOLD=2'd3.
  - NOP_INSTR and RESET_PC defaults.
- One natural sub-module: fetch_hold_buf, a 64-bit single-entry buffer with load/clear and a valid flag.

## Test plan
- Reset release, imem_ready=1, memory word = address: imem_addr is 0, 4, 8…; instrD equals PCD each cycle after the first; validD=1 from cycle 3.
- imem_ready held low 3 cycles at addr 8: imem_req and imem_addr=8 are stable all 3 cycles; instrD=NOP_INSTR with validD=0 until ready.
- stallD high 2 cycles while ready returns word at 12: state HOLD with imem_req=0, instrD unchanged; after release PCD=12, then fetch resumes at 16.
- PCSrcE with target 0x100 while a request at 0x20 is pending 2 more cycles: DROP keeps addr 0x20; the 0x20 word is never presented on instrD; the next request is 0x100.
- flushD and stallD together: instrD=NOP_INSTR, validD=0.
- Macro on, PCTargetE=0x102: imem_addr=0x100, misalignF=1 and it stays 1 after later aligned redirects.
